// File: rtl/setpoint_pkg.sv
// setpoint_pkg: shared mode encoding for setpoint_gen (OFF/CONST/SQUARE/RAMP)
package setpoint_pkg;
  typedef enum logic [1:0] {MODE_OFF, MODE_CONST, MODE_SQUARE, MODE_RAMP} mode_e;
endpackage

// File: rtl/setpoint_slew_limiter.sv
// slew_limiter: next = target if step==0 or |target-cur|<=step, else cur moved step toward target; ports cur,target,step -> nxt
module slew_limiter #(
  parameter int WIDTH = 16,
  parameter int STEP_W = 16
) (
  input logic signed [WIDTH-1:0] cur,
  input logic signed [WIDTH-1:0] target,
  input logic [STEP_W-1:0] step,
  output logic signed [WIDTH-1:0] nxt
);
  localparam int M = (WIDTH + 1 > STEP_W ? WIDTH + 1 : STEP_W) + 1;
  logic signed [M-1:0] diff, mag, stp, sum;
  always_comb begin
    diff = M'(target) - M'(cur);
    stp = M'(step);
    mag = diff[M-1] ? -diff : diff;
    sum = diff[M-1] ? M'(cur) - stp : M'(cur) + stp;
    nxt = (~|step || mag <= stp) ? target : sum[WIDTH-1:0];
  end
endmodule

// File: rtl/setpoint_gen.sv
// setpoint_gen: tick-driven OFF/CONST/SQUARE/RAMP setpoint with slew limit; in clk,rst,i_tick,i_mode,i_amp,i_half_period,i_slew; out o_aim,o_valid,o_phase,o_settled
module setpoint_gen
  import setpoint_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int PERIOD_W = 24,
  parameter int STEP_W = 16
) (
  input logic clk,
  input logic rst,
  input logic i_tick,
  input logic [1:0] i_mode,
  input logic [WIDTH-2:0] i_amp,
  input logic [PERIOD_W-1:0] i_half_period,
  input logic [STEP_W-1:0] i_slew,
  output logic signed [WIDTH-1:0] o_aim,
  output logic o_valid,
  output logic o_phase,
  output logic o_settled
);
  mode_e sh_mode, e_mode;
  logic [WIDTH-2:0] sh_amp, e_amp;
  logic [PERIOD_W-1:0] sh_half, e_half, cnt;
  logic load, last, hit;
  logic signed [WIDTH-1:0] pos, raw, nxt;
  always_comb begin
    load = cnt == '0 || sh_mode == MODE_OFF;
    e_mode = load ? mode_e'(i_mode) : sh_mode;
    e_amp = load ? i_amp : sh_amp;
    e_half = load ? i_half_period : sh_half;
    pos = {1'b0, e_amp};
    raw = e_mode == MODE_OFF ? '0 : (e_mode == MODE_CONST || o_phase) ? pos : -pos;
    last = e_half <= PERIOD_W'(1) || cnt >= e_half - PERIOD_W'(1);
    hit = nxt == raw;
  end
  slew_limiter #(.WIDTH(WIDTH), .STEP_W(STEP_W)) u_slew (
    .cur(o_aim),
    .target(raw),
    .step(i_slew),
    .nxt(nxt)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      o_aim <= '0;
      o_valid <= 1'b0;
      o_phase <= 1'b0;
      o_settled <= 1'b1;
      cnt <= '0;
      sh_mode <= MODE_OFF;
      sh_amp <= '0;
      sh_half <= '0;
    end else begin
      o_valid <= i_tick;
      if (i_tick) begin
        sh_mode <= e_mode;
        sh_amp <= e_amp;
        sh_half <= e_half;
        o_aim <= nxt;
        o_settled <= hit;
        cnt <= (e_mode == MODE_SQUARE && !last) ? cnt + PERIOD_W'(1) : '0;
        o_phase <= e_mode == MODE_OFF ? 1'b0 : e_mode == MODE_SQUARE ? o_phase ^ last : e_mode == MODE_RAMP ? o_phase ^ hit : o_phase;
      end
    end
endmodule

// File: tb/tb_setpoint_gen.sv
// tb_setpoint_gen: table-driven vectors plus reset, deferral and idle sequences for setpoint_gen
module tb_setpoint_gen;
  localparam int OFF = 0, CST = 1, SQR = 2, RMP = 3;
  typedef struct {
    bit rf;
    int mode, amp, half, slew, n, aim, ph, st;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, i_tick = 1'b0;
  logic [1:0] i_mode = '0;
  logic [14:0] i_amp = '0;
  logic [23:0] i_half_period = '0;
  logic [15:0] i_slew = '0;
  logic signed [15:0] o_aim;
  logic o_valid, o_phase, o_settled;
  int checks = 0, errors = 0;
  vec_t v[$];
  setpoint_gen dut (
    .clk(clk),
    .rst(rst),
    .i_tick(i_tick),
    .i_mode(i_mode),
    .i_amp(i_amp),
    .i_half_period(i_half_period),
    .i_slew(i_slew),
    .o_aim(o_aim),
    .o_valid(o_valid),
    .o_phase(o_phase),
    .o_settled(o_settled)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask
  task automatic add(input bit rf, input int mode, amp, half, slew, n, aim, ph, st);
    vec_t x;
    x.rf = rf; x.mode = mode; x.amp = amp; x.half = half; x.slew = slew;
    x.n = n; x.aim = aim; x.ph = ph; x.st = st;
    v.push_back(x);
  endtask
  task automatic set_in(input int mode, amp, half, slew);
    i_mode = 2'(mode);
    i_amp = 15'(amp);
    i_half_period = 24'(half);
    i_slew = 16'(slew);
  endtask
  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask
  task automatic do_tick();
    repeat (3) @(negedge clk);
    i_tick = 1'b1;
    @(negedge clk) i_tick = 1'b0;
  endtask
  task automatic chk_out(input string nm, input int aim, ph, st);
    chk({nm, "_aim"}, int'(o_aim), aim);
    chk({nm, "_phase"}, int'(o_phase), ph);
    chk({nm, "_settled"}, int'(o_settled), st);
    chk({nm, "_valid"}, int'(o_valid), 1);
  endtask
  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    add(1, SQR, 200, 4, 0, 1, -200, 0, 1);
    add(0, SQR, 200, 4, 0, 1, -200, 0, 1);
    add(0, SQR, 200, 4, 0, 1, -200, 0, 1);
    add(0, SQR, 200, 4, 0, 1, -200, 1, 1);
    add(0, SQR, 200, 4, 0, 1, 200, 1, 1);
    add(0, SQR, 200, 4, 0, 1, 200, 1, 1);
    add(0, SQR, 200, 4, 0, 1, 200, 1, 1);
    add(0, SQR, 200, 4, 0, 1, 200, 0, 1);
    add(0, SQR, 200, 4, 0, 1, -200, 0, 1);
    add(1, SQR, 200, 8, 50, 1, -50, 0, 0);
    add(0, SQR, 200, 8, 50, 1, -100, 0, 0);
    add(0, SQR, 200, 8, 50, 1, -150, 0, 0);
    add(0, SQR, 200, 8, 50, 1, -200, 0, 1);
    add(0, SQR, 200, 8, 50, 3, -200, 0, 1);
    add(0, SQR, 200, 8, 50, 1, -200, 1, 1);
    add(0, SQR, 200, 8, 50, 1, -150, 1, 0);
    add(0, SQR, 200, 8, 50, 1, -100, 1, 0);
    add(0, SQR, 200, 8, 50, 1, -50, 1, 0);
    add(0, SQR, 200, 8, 50, 1, 0, 1, 0);
    add(0, SQR, 200, 8, 50, 1, 50, 1, 0);
    add(0, SQR, 200, 8, 50, 1, 100, 1, 0);
    add(0, SQR, 200, 8, 50, 1, 150, 1, 0);
    add(0, SQR, 200, 8, 50, 1, 200, 0, 1);
    add(1, RMP, 100, 0, 30, 1, -30, 0, 0);
    add(0, RMP, 100, 0, 30, 1, -60, 0, 0);
    add(0, RMP, 100, 0, 30, 1, -90, 0, 0);
    add(0, RMP, 100, 0, 30, 1, -100, 1, 1);
    add(0, RMP, 100, 0, 30, 1, -70, 1, 0);
    add(0, RMP, 100, 0, 30, 1, -40, 1, 0);
    add(0, RMP, 100, 0, 30, 1, -10, 1, 0);
    add(0, RMP, 100, 0, 30, 1, 20, 1, 0);
    add(0, RMP, 100, 0, 30, 1, 50, 1, 0);
    add(0, RMP, 100, 0, 30, 1, 80, 1, 0);
    add(0, RMP, 100, 0, 30, 1, 100, 0, 1);
    add(0, RMP, 100, 0, 30, 1, 70, 0, 0);
    add(0, RMP, 100, 0, 0, 1, -100, 1, 1);
    add(0, RMP, 100, 0, 0, 1, 100, 0, 1);
    add(0, RMP, 100, 0, 0, 1, -100, 1, 1);
    add(1, CST, 32767, 0, 0, 1, 32767, 0, 1);
    add(0, OFF, 32767, 0, 16384, 1, 16383, 0, 0);
    add(0, OFF, 32767, 0, 16384, 1, 0, 0, 1);
    add(0, SQR, 0, 1, 0, 1, 0, 1, 1);
    add(0, SQR, 0, 1, 0, 1, 0, 0, 1);
    add(0, SQR, 10, 0, 0, 1, -10, 1, 1);
    add(0, SQR, 10, 0, 0, 1, 10, 0, 1);
    repeat (2) @(negedge clk);
    chk("reset_aim", int'(o_aim), 0);
    chk("reset_valid", int'(o_valid), 0);
    chk("reset_phase", int'(o_phase), 0);
    chk("reset_settled", int'(o_settled), 1);
    rst = 1'b0;
    for (int i = 0; i < v.size(); i++) begin
      if (v[i].rf) do_reset();
      set_in(v[i].mode, v[i].amp, v[i].half, v[i].slew);
      repeat (v[i].n) do_tick();
      chk_out($sformatf("vec%0d", i), v[i].aim, v[i].ph, v[i].st);
    end
    @(negedge clk);
    chk("idle_valid", int'(o_valid), 0);
    set_in(SQR, 77, 3, 0);
    repeat (4) @(negedge clk);
    chk("idle_aim", int'(o_aim), 10);
    chk("idle_phase", int'(o_phase), 0);
    do_reset();
    set_in(SQR, 200, 4, 0);
    do_tick();
    do_tick();
    set_in(SQR, 50, 4, 0);
    do_tick();
    chk_out("defer_t3", -200, 0, 1);
    do_tick();
    chk_out("defer_t4", -200, 1, 1);
    do_tick();
    chk_out("defer_t5", 50, 1, 1);
    do_reset();
    set_in(RMP, 100, 0, 30);
    repeat (5) do_tick();
    chk_out("pre_rst", -70, 1, 0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_aim", int'(o_aim), 0);
    chk("async_rst_phase", int'(o_phase), 0);
    chk("async_rst_settled", int'(o_settled), 1);
    chk("async_rst_valid", int'(o_valid), 0);
    @(negedge clk) rst = 1'b0;
    do_tick();
    chk_out("post_rst", -30, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/setpoint_gen.md
SETPOINT_GEN -- requirements
Module: setpoint_gen

Interface
REQ-001 Parameter WIDTH, default 16, bit width of the signed setpoint output.
REQ-002 Parameter PERIOD_W, default 24, width of the half-period tick counter.
REQ-003 Parameter STEP_W, default 16, width of the slew-step input.
REQ-004 clk  input  1  sole clock; all logic rising-edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 i_tick  input  1  one-cycle control-period strobe (driven from en_idq).
REQ-007 i_mode  input  2  0=OFF, 1=CONST, 2=SQUARE, 3=RAMP.
REQ-008 i_amp  input  WIDTH-1  unsigned magnitude A; the output range is +/-A.
REQ-009 i_half_period  input  PERIOD_W  SQUARE half-period in ticks.
REQ-010 i_slew  input  STEP_W  maximum output change per tick; 0 means unlimited.
REQ-011 o_aim  output  WIDTH  signed setpoint (feeds iq_aim or id_aim).
REQ-012 o_valid  output  1  one-cycle pulse when o_aim is updated.
REQ-013 o_phase  output  1  current half: 1=positive, 0=negative.
REQ-014 o_settled  output  1  high when o_aim equals the raw target.

Function
REQ-015 The block SHALL do nothing on cycles without i_tick; all state changes occur only on i_tick cycles.
REQ-016 Shadow registers for mode, A and half-period SHALL load on a tick when cnt==0 or shadow mode==OFF; changes mid-half-period are deferred.
REQ-017 On each tick in SQUARE: if cnt>=max(i_half_period,1)-1, then cnt<=0 and o_phase toggles; else cnt increments. A half-period of 0 SHALL behave as 1.
REQ-018 Raw target SHALL be as follows.
- OFF: 0.
- CONST: +A.
- SQUARE: o_phase ? +A : -A.
- RAMP: o_phase ? +A : -A, with o_phase toggling on the tick where o_aim reaches that target (triangle; i_half_period ignored).
REQ-019 Slew limiting: diff = raw - o_aim, computed in WIDTH+1 bits.
- If i_slew==0 or |diff|<=i_slew: o_aim <= raw.
- Else: o_aim <= o_aim + sign(diff)*i_slew.
REQ-020 In RAMP with i_slew==0, o_aim SHALL alternate between +A and -A on every tick.
REQ-021 Arithmetic SHALL never overflow, because |o_aim| <= A <= 2^(WIDTH-1)-1; no saturation logic is required beyond this.
REQ-022 o_aim and o_valid SHALL update exactly 1 cycle after i_tick (o_valid high in the same cycle as the new o_aim).
REQ-023 o_settled SHALL be registered together with o_aim and computed against the same raw target.
REQ-024 Mode change to OFF SHALL slew o_aim to 0 at i_slew per tick and SHALL hold cnt=0 and o_phase=0.
REQ-025 A=0 SHALL hold o_aim=0 and o_settled=1 in every mode.

Reset
REQ-026 On rst: o_aim=0, o_valid=0, o_phase=0, o_settled=1, cnt=0, shadow mode=OFF.
REQ-027 Reset asserted mid-operation (including mid-ramp) SHALL take effect immediately, asynchronously.
REQ-028 After rst deasserts, the first tick SHALL load the shadows; the first SQUARE or RAMP half is negative.

Structure
REQ-029 The mode encoding enum (OFF/CONST/SQUARE/RAMP) SHALL reside in shared package setpoint_pkg.
REQ-030 The slew limiter (REQ-019) SHALL be a sub-module, slew_limiter, parametrised by WIDTH and STEP_W.
REQ-031 The replaced behaviour is the fixed +/-200 square-wave setpoint logic in the FPGA top; the top SHALL instantiate setpoint_gen in its place.

Verification
REQ-032 SQUARE, A=200, half=4, slew=0, tick every 8 clk -> o_aim = -200 x4, +200 x4, repeating; o_valid 1 cycle after each tick.
REQ-033 SQUARE, A=200, half=10, slew=50 -> at each edge o_aim steps 50 per tick: -200,-150,...,+200 (8 ticks); o_settled low during steps.
REQ-034 RAMP, A=100, slew=30 -> o_aim = -30,-60,-90,-100,-70,...,+100, then reverses; o_phase toggles on the ticks reaching -100 and +100.
REQ-035 Change i_amp 200->50 at cnt=2 of half=4 -> o_aim stays at +/-200 until the next half-period boundary, then +/-50.
REQ-036 CONST, A=32767, slew=0 -> o_aim=+32767; switch to OFF with slew=16384 -> o_aim = 16383, then 0; no overflow.
REQ-037 Assert rst mid-RAMP -> all outputs take their reset values in the same cycle; after release, the first tick starts from a negative half.
